// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: program counter, instruction-memory read port and a
// 2-entry {pc, instr, misaligned} queue feeding decode over valid/ready.
// Redirects from execute flush the queue; a misaligned target queues a single
// trap marker and halts fetching until the next redirect.
module if_fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  imem_read_enable,
  output logic [ADDR_WIDTH-1:0] imem_read_address,
  input  logic [DATA_WIDTH-1:0] imem_read_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  out_misaligned
);

  localparam int unsigned DEPTH_W = 2;
  localparam logic [ADDR_WIDTH-1:0] PC_RESET = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
    logic                  misaligned;
  } entry_t;

  state_t               state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [DEPTH_W-1:0]   count;
  entry_t               slot0;  // queue head
  entry_t               slot1;  // queue tail when two entries are held

  logic   pop;
  logic   fetch;
  logic   target_misaligned;
  entry_t fetched;
  entry_t trap_entry;

  // Handshake, fetch decision and entry formation for the current cycle
  always_comb begin
    pop               = (count != '0) && out_ready;
    target_misaligned = (redirect_pc[1:0] != 2'b00);
    fetch             = !reset && (state == RUN) && !redirect_valid &&
                        ((count < DEPTH_W'(2)) || pop);
    fetched           = {pc, imem_read_data, 1'b0};
    trap_entry        = {redirect_pc, {DATA_WIDTH{1'b0}}, 1'b1};
  end

  // Memory read port: the address always tracks the PC, the strobe marks a real fetch
  always_comb begin
    imem_read_enable  = fetch;
    imem_read_address = pc;
  end

  // Decode-side view of the queue head; fields forced to zero when empty
  always_comb begin
    out_valid      = (count != '0);
    out_instr      = '0;
    out_pc         = '0;
    out_misaligned = 1'b0;
    if (out_valid) begin
      out_instr      = slot0.instr;
      out_pc         = slot0.pc;
      out_misaligned = slot0.misaligned;
    end
  end

  // Fetch FSM and program counter; redirects take priority over sequential fetch
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
      pc    <= PC_RESET;
    end else if (redirect_valid) begin
      if (target_misaligned) begin
        state <= HALT;
        pc    <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      end else begin
        state <= RUN;
        pc    <= redirect_pc;
      end
    end else if (fetch) begin
      pc <= pc + PC_STEP;
    end
  end

  // Two-entry queue: flush on redirect, otherwise push fetched words and pop on handshake
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (redirect_valid) begin
      if (target_misaligned) begin
        slot0 <= trap_entry;
        count <= DEPTH_W'(1);
      end else begin
        count <= '0;
      end
    end else begin
      unique case ({fetch, pop})
        2'b10: begin
          if (count == '0) begin
            slot0 <= fetched;
          end else begin
            slot1 <= fetched;
          end
          count <= count + DEPTH_W'(1);
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - DEPTH_W'(1);
        end
        2'b11: begin
          if (count == DEPTH_W'(1)) begin
            slot0 <= fetched;
          end else begin
            slot0 <= slot1;
            slot1 <= fetched;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: per-cycle vector table plus a scoreboard of fetched
// words that is checked on every decode handshake. Memory word at address n is n.
module tb_if_fetch_unit;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  logic          clock;
  logic          reset;
  logic          imem_read_enable;
  logic [AW-1:0] imem_read_address;
  logic [DW-1:0] imem_read_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          out_misaligned;

  if_fetch_unit #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .RESET_PC  (0)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .imem_read_enable (imem_read_enable),
    .imem_read_address(imem_read_address),
    .imem_read_data   (imem_read_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_pc           (out_pc),
    .out_misaligned   (out_misaligned)
  );

  // Instruction memory model: each word holds its own byte address
  assign imem_read_data = DW'(imem_read_address);

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic          rv;
    logic [AW-1:0] rpc;
    logic          rdy;
    logic          ev;
    logic [AW-1:0] epc;
    logic          emis;
    logic          eren;
    logic [AW-1:0] eaddr;
  } vec_t;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
    logic          mis;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rv, input logic [AW-1:0] rpc, input logic rdy,
                     input logic ev, input logic [AW-1:0] epc, input logic emis,
                     input logic eren, input logic [AW-1:0] eaddr);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.emis = emis;
    v.eren = eren; v.eaddr = eaddr;
    tbl.push_back(v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out_valid"},        32'(out_valid), 32'd0);
    check({tag, " out_pc"},           32'(out_pc), 32'd0);
    check({tag, " out_instr"},        out_instr, 32'd0);
    check({tag, " out_misaligned"},   32'(out_misaligned), 32'd0);
    check({tag, " imem_read_enable"}, 32'(imem_read_enable), 32'd0);
    check({tag, " imem_read_address"}, 32'(imem_read_address), 32'd0);
  endtask

  // Applies vectors lo..hi, one per cycle, starting at a falling edge
  task automatic run_vectors(input int lo, input int hi);
    vec_t v;
    sb_t  e;
    logic [DW-1:0] exp_instr;
    for (int i = lo; i <= hi; i++) begin
      v = tbl[i];
      redirect_valid = v.rv;
      redirect_pc    = v.rpc;
      out_ready      = v.rdy;
      #1;
      exp_instr = (v.ev && !v.emis) ? DW'(v.epc) : '0;
      check($sformatf("v%0d out_valid", i),        32'(out_valid), 32'(v.ev));
      check($sformatf("v%0d out_pc", i),           32'(out_pc), v.ev ? 32'(v.epc) : 32'd0);
      check($sformatf("v%0d out_instr", i),        out_instr, exp_instr);
      check($sformatf("v%0d out_misaligned", i),   32'(out_misaligned), 32'(v.ev && v.emis));
      check($sformatf("v%0d imem_read_enable", i), 32'(imem_read_enable), 32'(v.eren));
      if (v.eren) begin
        check($sformatf("v%0d imem_read_address", i), 32'(imem_read_address), 32'(v.eaddr));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check($sformatf("v%0d sb_underflow", i), 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check($sformatf("v%0d sb pc", i),    32'(out_pc), 32'(e.pc));
          check($sformatf("v%0d sb instr", i), out_instr, e.instr);
          check($sformatf("v%0d sb mis", i),   32'(out_misaligned), 32'(e.mis));
        end
      end
      if (v.rv) begin
        sb.delete();
        if (v.rpc[1:0] != 2'b00) begin
          e.pc = v.rpc; e.instr = '0; e.mis = 1'b1;
          sb.push_back(e);
        end
      end
      if (v.eren) begin
        e.pc = v.eaddr; e.instr = DW'(v.eaddr); e.mis = 1'b0;
        sb.push_back(e);
      end
      @(negedge clock);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end by 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table 1: streaming, mid-stream stall, redirects, trap, wrap
    add(0, 'h000, 1, 0, 'h000, 0, 1, 'h000);
    add(0, 'h000, 1, 1, 'h000, 0, 1, 'h004);
    add(0, 'h000, 1, 1, 'h004, 0, 1, 'h008);
    add(0, 'h000, 1, 1, 'h008, 0, 1, 'h00C);
    add(0, 'h000, 1, 1, 'h00C, 0, 1, 'h010);
    add(0, 'h000, 0, 1, 'h010, 0, 1, 'h014);
    add(0, 'h000, 0, 1, 'h010, 0, 0, 'h000);
    add(0, 'h000, 0, 1, 'h010, 0, 0, 'h000);
    add(0, 'h000, 1, 1, 'h010, 0, 1, 'h018);
    add(0, 'h000, 1, 1, 'h014, 0, 1, 'h01C);
    add(0, 'h000, 1, 1, 'h018, 0, 1, 'h020);
    add(0, 'h000, 0, 1, 'h01C, 0, 0, 'h000);
    add(1, 'h100, 0, 1, 'h01C, 0, 0, 'h000);
    add(0, 'h000, 1, 0, 'h000, 0, 1, 'h100);
    add(0, 'h000, 1, 1, 'h100, 0, 1, 'h104);
    add(1, 'h102, 1, 1, 'h104, 0, 0, 'h000);
    add(0, 'h000, 0, 1, 'h102, 1, 0, 'h000);
    add(0, 'h000, 1, 1, 'h102, 1, 0, 'h000);
    for (int k = 0; k < 7; k++) add(0, 'h000, 1, 0, 'h000, 0, 0, 'h000);
    add(1, 'h200, 1, 0, 'h000, 0, 0, 'h000);
    add(0, 'h000, 1, 0, 'h000, 0, 1, 'h200);
    add(0, 'h000, 1, 1, 'h200, 0, 1, 'h204);
    add(1, 'hFF8, 1, 1, 'h204, 0, 0, 'h000);
    add(0, 'h000, 1, 0, 'h000, 0, 1, 'hFF8);
    add(0, 'h000, 1, 1, 'hFF8, 0, 1, 'hFFC);
    add(0, 'h000, 1, 1, 'hFFC, 0, 1, 'h000);
    add(0, 'h000, 1, 1, 'h000, 0, 1, 'h004);
    add(0, 'h000, 1, 1, 'h004, 0, 1, 'h008);
    // Table 2 (indices 34..42): decode stalled from reset release, then released
    add(0, 'h000, 0, 0, 'h000, 0, 1, 'h000);
    add(0, 'h000, 0, 1, 'h000, 0, 1, 'h004);
    add(0, 'h000, 0, 1, 'h000, 0, 0, 'h000);
    add(0, 'h000, 0, 1, 'h000, 0, 0, 'h000);
    add(0, 'h000, 0, 1, 'h000, 0, 0, 'h000);
    add(0, 'h000, 1, 1, 'h000, 0, 1, 'h008);
    add(0, 'h000, 1, 1, 'h004, 0, 1, 'h00C);
    add(0, 'h000, 1, 1, 'h008, 0, 1, 'h010);
    add(0, 'h000, 1, 1, 'h00C, 0, 1, 'h014);

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    #1;
    check_reset_outputs("por");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    run_vectors(0, 33);

    // Reset mid-stream between edges, with a redirect in flight
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    #2;
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 'h300;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    @(negedge clock);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    run_vectors(34, 42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
